// File: rtl/instr_encoder_if.sv
// Bundle between the instruction source, the encoder and the byte-wide instruction memory port.
// Handshake: a transfer happens on a rising clock edge where in_valid and in_ready are both high.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sa;
    logic [15:0]       imm;
    logic [25:0]       jaddr;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [7:0]        im_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              err_ill;
    logic              err_ovf;

    modport master (
        output start, in_valid, mnem, rs, rt, rd, sa, imm, jaddr,
        input  in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, err_ill, err_ovf
    );

    modport slave (
        input  start, in_valid, mnem, rs, rt, rd, sa, imm, jaddr,
        output in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, err_ill, err_ovf
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs mnemonic + operand fields into 32-bit instructions and streams them big-endian,
// one byte per cycle, into instruction memory while holding the CPU frozen.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                CLK,
    input  logic                Reset,
    instr_encoder_if.slave      bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   BASE = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W+1:0] CAP  = {2'b01, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       word_q, word_d;
    logic              halt_q, halt_d;
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [7:0]        im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ovf_q, err_ovf_d;

    logic [31:0]       enc_word;
    logic              enc_ill;
    logic [ADDR_W+1:0] cnt_next;

    always_comb begin
        enc_word = 32'h0;
        enc_ill  = 1'b0;
        case (bus.mnem)
            4'd0:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, bus.sa, 6'b0};
            4'd1:  enc_word = {6'b000001, bus.rs, bus.rt, bus.imm};
            4'd2:  enc_word = {6'b000010, bus.rs, bus.rt, bus.rd, bus.sa, 6'b0};
            4'd3:  enc_word = {6'b010000, bus.rs, bus.rt, bus.imm};
            4'd4:  enc_word = {6'b010001, bus.rs, bus.rt, bus.rd, bus.sa, 6'b0};
            4'd5:  enc_word = {6'b010010, bus.rs, bus.rt, bus.rd, bus.sa, 6'b0};
            // sll takes its source from rt, so the rs slot is always zero
            4'd6:  enc_word = {6'b011000, 5'b0, bus.rt, bus.rd, bus.sa, 6'b0};
            4'd7:  enc_word = {6'b011011, bus.rs, bus.rt, bus.imm};
            4'd8:  enc_word = {6'b100110, bus.rs, bus.rt, bus.imm};
            4'd9:  enc_word = {6'b100111, bus.rs, bus.rt, bus.imm};
            4'd10: enc_word = {6'b110000, bus.rs, bus.rt, bus.imm};
            4'd11: enc_word = {6'b110001, bus.rs, bus.rt, bus.imm};
            4'd12: enc_word = {6'b111000, bus.jaddr};
            4'd13: enc_word = {6'b111111, 26'b0};
            default: enc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        word_d      = word_q;
        halt_d      = halt_q;
        in_ready_d  = in_ready_q;
        im_we_d     = 1'b0;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        err_ill_d   = err_ill_q;
        err_ovf_d   = err_ovf_q;
        // Extra headroom bit so counter+4 cannot wrap in the fit test
        cnt_next    = {1'b0, cnt_q} + (ADDR_W+2)'(4);

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b0;
                if (bus.start) begin
                    state_d     = S_ACCEPT;
                    cnt_d       = BASE;
                    in_ready_d  = 1'b1;
                    cpu_hold_d  = 1'b1;
                    load_done_d = 1'b0;
                    err_ill_d   = 1'b0;
                    err_ovf_d   = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (bus.in_valid && in_ready_q) begin
                    if (enc_ill) begin
                        err_ill_d = 1'b1;
                    end else if (cnt_next > CAP) begin
                        err_ovf_d  = 1'b1;
                        in_ready_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d    = S_WRITE;
                        word_d     = enc_word;
                        halt_d     = (bus.mnem == 4'd13);
                        k_d        = 2'd0;
                        in_ready_d = 1'b0;
                        im_we_d    = 1'b1;
                        im_addr_d  = cnt_q[ADDR_W-1:0];
                        im_wdata_d = enc_word[31:24];
                    end
                end
            end
            S_WRITE: begin
                if (k_q != 2'd3) begin
                    k_d       = k_q + 2'd1;
                    im_we_d   = 1'b1;
                    im_addr_d = cnt_q[ADDR_W-1:0] + ADDR_W'(k_d);
                    case (k_d)
                        2'd1:    im_wdata_d = word_q[23:16];
                        2'd2:    im_wdata_d = word_q[15:8];
                        default: im_wdata_d = word_q[7:0];
                    endcase
                end else begin
                    cnt_d = cnt_q + (ADDR_W+1)'(4);
                    if (halt_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        in_ready_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = S_ACCEPT;
                    end
                end
            end
            default: begin
                in_ready_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= BASE;
            k_q         <= 2'd0;
            word_q      <= 32'h0;
            halt_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= 8'h0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            err_ill_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            word_q      <= word_d;
            halt_q      <= halt_d;
            in_ready_q  <= in_ready_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            err_ill_q   <= err_ill_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.im_we     = im_we_q;
    assign bus.im_addr   = im_addr_q;
    assign bus.im_wdata  = im_wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.load_done = load_done_q;
    assign bus.err_ill   = err_ill_q;
    assign bus.err_ovf   = err_ovf_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: one 256-byte instance for encoding/flow, one 16-byte instance for overflow.
module tb_instr_encoder;
    localparam int AW_A = 8;
    localparam int AW_B = 4;

    logic CLK = 1'b0;
    logic Reset = 1'b0;
    always #5 CLK = ~CLK;

    instr_encoder_if #(.ADDR_W(AW_A)) ifa ();
    instr_encoder_if #(.ADDR_W(AW_B)) ifb ();
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    instr_encoder #(.ADDR_W(AW_A), .BASE_ADDR(0)) dut_a (
        .CLK(CLK), .Reset(Reset), .bus(ifa.slave), .dbg_state(dbg_a));
    instr_encoder #(.ADDR_W(AW_B), .BASE_ADDR(0)) dut_b (
        .CLK(CLK), .Reset(Reset), .bus(ifb.slave), .dbg_state(dbg_b));

    logic [3:0]  t_mnem;
    logic [4:0]  t_rs, t_rt, t_rd, t_sa;
    logic [15:0] t_imm;
    logic [25:0] t_jaddr;
    logic        st_a, st_b, iv_a, iv_b;

    assign ifa.start = st_a;    assign ifb.start = st_b;
    assign ifa.in_valid = iv_a; assign ifb.in_valid = iv_b;
    assign ifa.mnem = t_mnem;   assign ifb.mnem = t_mnem;
    assign ifa.rs = t_rs;       assign ifb.rs = t_rs;
    assign ifa.rt = t_rt;       assign ifb.rt = t_rt;
    assign ifa.rd = t_rd;       assign ifb.rd = t_rd;
    assign ifa.sa = t_sa;       assign ifb.sa = t_sa;
    assign ifa.imm = t_imm;     assign ifb.imm = t_imm;
    assign ifa.jaddr = t_jaddr; assign ifb.jaddr = t_jaddr;

    int n_vec = 0;
    int n_err = 0;
    int addr_a = 0;
    int addr_b = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoding straight from the opcode table and field layout rules
    function automatic logic [31:0] model_word(input int m, input int rs, input int rt, input int rd,
                                               input int sa, input int imm, input int jaddr);
        int op[0:13];
        int w;
        op = '{0, 1, 2, 16, 17, 18, 24, 27, 38, 39, 48, 49, 56, 63};
        w = op[m] * 67108864;
        if (m == 0 || m == 2 || m == 4 || m == 5 || m == 6)
            w = w + ((m == 6) ? 0 : rs * 2097152) + rt * 65536 + rd * 2048 + sa * 64;
        else if (m == 12)
            w = w + jaddr;
        else if (m != 13)
            w = w + rs * 2097152 + rt * 65536 + imm;
        return 32'(w);
    endfunction

    task automatic send(input bit b, input int m, input int rs, input int rt, input int rd,
                        input int sa, input int imm, input int jaddr);
        int waitc;
        int addr;
        int cap;
        logic [31:0] w;
        @(negedge CLK);
        t_mnem = 4'(m); t_rs = 5'(rs); t_rt = 5'(rt); t_rd = 5'(rd); t_sa = 5'(sa);
        t_imm = 16'(imm); t_jaddr = 26'(jaddr);
        if (b) iv_b = 1'b1; else iv_a = 1'b1;
        waitc = 0;
        while (!(b ? ifb.in_ready : ifa.in_ready) && waitc < 40) begin
            @(negedge CLK);
            waitc++;
        end
        if (waitc >= 40) begin
            n_vec++; n_err++;
            $display("FAIL handshake_timeout: in_ready low for %0d cycles, expected high", waitc);
        end
        @(posedge CLK);
        #1;
        iv_a = 1'b0; iv_b = 1'b0;
        // Scramble inputs to show the word was captured at the handshake
        t_mnem = 4'($urandom_range(0, 15)); t_rs = 5'($urandom_range(0, 31));
        t_rt = 5'($urandom_range(0, 31)); t_rd = 5'($urandom_range(0, 31));
        t_sa = 5'($urandom_range(0, 31)); t_imm = 16'($urandom_range(0, 65535));
        t_jaddr = 26'($urandom);
        if (waitc < 40 && m < 14) begin
            w = model_word(m, rs, rt, rd, sa, imm, jaddr);
            addr = b ? addr_b : addr_a;
            cap = b ? (1 << AW_B) : (1 << AW_A);
            if (addr + 4 <= cap) begin
                for (int k = 0; k < 4; k++) begin
                    if (b) exp_b.push_back({8'(addr + k), w[31-8*k -: 8]});
                    else   exp_a.push_back({8'(addr + k), w[31-8*k -: 8]});
                end
                if (b) addr_b = addr + 4; else addr_a = addr + 4;
            end
        end
    endtask

    task automatic do_start(input bit b);
        @(negedge CLK);
        if (b) st_b = 1'b1; else st_a = 1'b1;
        @(posedge CLK);
        #1;
        st_a = 1'b0; st_b = 1'b0;
        if (b) addr_b = 0; else addr_a = 0;
        @(negedge CLK);
        check(b ? "b_start_in_ready" : "a_start_in_ready", 32'(b ? ifb.in_ready : ifa.in_ready), 32'd1);
        check(b ? "b_start_cpu_hold" : "a_start_cpu_hold", 32'(b ? ifb.cpu_hold : ifa.cpu_hold), 32'd1);
        check(b ? "b_start_flags" : "a_start_flags",
              32'(b ? {ifb.load_done, ifb.err_ill, ifb.err_ovf} : {ifa.load_done, ifa.err_ill, ifa.err_ovf}),
              32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'({ifa.in_ready, ifb.in_ready}), 32'd0);
        check("rst_im_we", 32'({ifa.im_we, ifb.im_we}), 32'd0);
        check("rst_im_addr_a", 32'(ifa.im_addr), 32'd0);
        check("rst_im_addr_b", 32'(ifb.im_addr), 32'd0);
        check("rst_im_wdata", 32'({ifa.im_wdata, ifb.im_wdata}), 32'd0);
        check("rst_cpu_hold", 32'({ifa.cpu_hold, ifb.cpu_hold}), 32'd0);
        check("rst_flags_a", 32'({ifa.load_done, ifa.err_ill, ifa.err_ovf}), 32'd0);
        check("rst_flags_b", 32'({ifb.load_done, ifb.err_ill, ifb.err_ovf}), 32'd0);
    endtask

    // Byte-write scoreboards: every write must match the next expected {addr, data}
    always @(negedge CLK) begin : cmp_a
        logic [15:0] e;
        if (ifa.im_we === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL a_unexpected_write: addr=%h data=%h, expected no write", ifa.im_addr, ifa.im_wdata);
            end else begin
                e = exp_a.pop_front();
                check("a_write", {16'h0, ifa.im_addr, ifa.im_wdata}, {16'h0, e});
            end
        end
    end

    always @(negedge CLK) begin : cmp_b
        logic [15:0] e;
        if (ifb.im_we === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL b_unexpected_write: addr=%h data=%h, expected no write", ifb.im_addr, ifb.im_wdata);
            end else begin
                e = exp_b.pop_front();
                check("b_write", {16'h0, 4'h0, ifb.im_addr, ifb.im_wdata}, {16'h0, e});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lowc;
        st_a = 0; st_b = 0; iv_a = 0; iv_b = 0;
        t_mnem = 0; t_rs = 0; t_rt = 0; t_rd = 0; t_sa = 0; t_imm = 0; t_jaddr = 0;

        repeat (3) @(negedge CLK);
        check_reset_outputs();
        Reset = 1'b1;

        // Hand-computed words pin the model
        check("pin_addi", model_word(1, 0, 1, 0, 0, 8, 0), 32'h04010008);
        check("pin_add",  model_word(0, 1, 2, 3, 0, 0, 0), 32'h00221800);
        check("pin_sll",  model_word(6, 5, 1, 2, 2, 0, 0), 32'h60011080);
        check("pin_beq",  model_word(10, 1, 2, 0, 0, 16'hFFFE, 0), 32'hC022FFFE);
        check("pin_j",    model_word(12, 0, 0, 0, 0, 0, 4), 32'hE0000004);
        check("pin_halt", model_word(13, 7, 7, 7, 7, 7, 7), 32'hFC000000);

        // in_valid without start: nothing accepted, nothing written
        iv_a = 1'b1; t_mnem = 4'd0;
        lowc = 0;
        repeat (10) begin
            @(negedge CLK);
            if (ifa.in_ready === 1'b0) lowc++;
        end
        check("idle_no_ready", 32'(lowc), 32'd10);
        iv_a = 1'b0;

        do_start(0);
        send(0, 1, 0, 1, 0, 0, 8, 0);
        lowc = 0;
        @(negedge CLK);
        while (ifa.in_ready !== 1'b1 && lowc < 20) begin
            lowc++;
            @(negedge CLK);
        end
        check("in_ready_low_cycles", 32'(lowc), 32'd4);

        send(0, 0, 1, 2, 3, 0, 0, 0);
        send(0, 14, 3, 3, 3, 3, 3, 3);
        @(negedge CLK);
        check("ill_err", 32'(ifa.err_ill), 32'd1);
        check("ill_ready_stays", 32'(ifa.in_ready), 32'd1);
        check("ill_no_write", 32'(ifa.im_we), 32'd0);
        send(0, 6, 5, 1, 2, 2, 0, 0);
        send(0, 10, 1, 2, 0, 0, 16'hFFFE, 0);
        send(0, 12, 0, 0, 0, 0, 0, 4);
        send(0, 13, 9, 9, 9, 9, 9, 9);
        repeat (4) @(negedge CLK);
        check("halt_byte3_hold", 32'({ifa.im_we, ifa.cpu_hold, ifa.load_done}), 32'b110);
        @(negedge CLK);
        check("halt_release", 32'({ifa.cpu_hold, ifa.load_done, ifa.in_ready}), 32'b010);
        check("ill_sticky", 32'(ifa.err_ill), 32'd1);

        // Reset in the middle of a word
        do_start(0);
        send(0, 2, 4, 5, 6, 1, 0, 0);
        repeat (3) @(negedge CLK);
        #2 Reset = 1'b0;
        #1;
        check_reset_outputs();
        check("abandoned_bytes", 32'(exp_a.size()), 32'd1);
        exp_a.delete();
        @(negedge CLK);
        Reset = 1'b1;

        // Small memory: four words fit, the fifth overflows
        do_start(1);
        for (int i = 0; i < 4; i++) send(1, 5, i, i + 1, i + 2, i, 0, 0);
        send(1, 1, 3, 4, 0, 0, 16'h1234, 0);
        @(negedge CLK);
        check("ovf_flags", 32'({ifb.err_ovf, ifb.cpu_hold, ifb.in_ready}), 32'b110);
        repeat (4) @(negedge CLK);
        check("ovf_idle", 32'({ifb.in_ready, ifb.im_we}), 32'd0);
        do_start(1);
        send(1, 13, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge CLK);
        check("b_halt_done", 32'({ifb.load_done, ifb.cpu_hold}), 32'b10);

        repeat (3) @(negedge CLK);
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        $display("debug states at end: a=%0d b=%0d", dbg_a, dbg_b);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Builds the instruction stream that the single-cycle CPU's opcode decoder consumes. It accepts one instruction per valid/ready handshake as a mnemonic index plus operand fields, and packs it into the 32-bit instruction format. It then writes the word big-endian, one byte per cycle, into the byte-wide instruction memory write port. While a load is in progress it holds the CPU frozen through `cpu_hold`, and it releases the CPU once a `halt` has been written.

## Interface
- `ADDR_W`, 8: instruction-memory byte-address width; capacity is 2^ADDR_W bytes.
- `BASE_ADDR`, 0: first byte address of each load; must be a multiple of 4 and less than 2^ADDR_W.

- `CLK`  in  1  clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load; honoured only in IDLE.
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  encoder can accept an instruction.
- `mnem`  in  4  mnemonic index: 0 add, 1 addi, 2 sub, 3 ori, 4 and, 5 or, 6 sll, 7 slti, 8 sw, 9 lw, 10 beq, 11 bne, 12 j, 13 halt; 14–15 illegal.
- `rs`, `rt`, `rd`, `sa`  in  5 each  register and shift fields.
- `imm`  in  16  immediate.
- `jaddr`  in  26  jump target (word address).
- `im_we`  out  1  instruction-memory byte write enable.
- `im_addr`  out  ADDR_W  byte address.
- `im_wdata`  out  8  byte data.
- `cpu_hold`  out  1  forces PCWre low in the CPU while set.
- `load_done`  out  1  sticky; a halt was written in the current load.
- `err_ill`  out  1  sticky; an illegal mnemonic was received.
- `err_ovf`  out  1  sticky; an instruction did not fit in memory.

## Operation
- **Opcodes** (placed in bits 31:26):
  - add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, sll 011000, slti 011011
  - sw 100110, lw 100111, beq 110000, bne 110001, j 111000, halt 111111
- **R format** (add, sub, and, or): op | rs[25:21] | rt[20:16] | rd[15:11] | sa[10:6] | 0[5:0].
- **sll**: same as R format, but rs is forced to 0.
- **I format** (addi, ori, slti, sw, lw, beq, bne): op | rs | rt | imm[15:0].
- **j**: op | jaddr[25:0].
- **halt**: op | 0.
- Fields that are unused by a format are ignored. The encoded word is latched at acceptance, so the inputs may change after the handshake.
- **IDLE**:
  - `in_ready`=0.
  - `start` → ACCEPT. This loads the address counter with BASE_ADDR, sets `cpu_hold`=1, and clears `load_done`, `err_ill` and `err_ovf`.
- **ACCEPT**:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - illegal `mnem` → set `err_ill`, write nothing, stay in ACCEPT.
    - otherwise, if counter+4 > 2^ADDR_W → set `err_ovf`, write nothing, go to IDLE with `cpu_hold` still 1.
    - otherwise → WRITE with byte index k=0.
- **WRITE**:
  - Each cycle: `im_we`=1, `im_addr`=counter+k, `im_wdata`=word[31-8k:24-8k].
  - After k=3: counter += 4.
  - If the word was halt → `load_done`=1, `cpu_hold`=0, go to IDLE. Otherwise go to ACCEPT.
- The address counter is ADDR_W+1 bits wide, so it never wraps silently.
- `start` outside IDLE is ignored.

## Timing
- **Reset values**:
  - state IDLE
  - `in_ready`, `im_we`, `load_done`, `err_ill`, `err_ovf` = 0
  - `im_addr`, `im_wdata` = 0
  - `cpu_hold`=0
  - counter = BASE_ADDR
- All outputs are registered.
- A handshake at edge T produces byte writes in cycles T+1 through T+4 (`im_we` high for exactly 4 cycles).
- `in_ready` returns high in cycle T+5, giving 5 cycles per instruction.
- An illegal-mnemonic handshake keeps `in_ready` high the next cycle.
- On halt, `cpu_hold` and `load_done` update at the same edge as the end of byte 3.
- A `start` at edge T makes `in_ready`=1 and `cpu_hold`=1 in cycle T+1.
- Reset asserted mid-WRITE abandons the partial word immediately (asynchronous). Bytes already written stay in memory.

## Test plan
- Reset, `start`, then addi rs=0 rt=1 imm=8 → bytes 04,01,00,08 at addresses 0–3 on consecutive cycles; `in_ready` low for exactly 4 cycles.
- add rs=1 rt=2 rd=3 → word 0x00221800. sll rs=5 rt=1 rd=2 sa=2 → 0x60011080 (rs dropped).
- beq rs=1 rt=2 imm=0xFFFE → 0xC022FFFE. j jaddr=4 → 0xE0000004. Then halt → 0xFC000000, `load_done`=1, `cpu_hold`=0 at the end of its byte 3.
- `mnem`=14 mid-load → `err_ill`=1, no `im_we`, the next valid instruction is written at the unchanged address.
- ADDR_W=4: four non-halt words fill addresses 0–15; a fifth → `err_ovf`=1, no write, IDLE with `cpu_hold`=1. A subsequent `start` clears `err_ovf`.
- Reset asserted during byte 2 of a word → all outputs at reset values at once. `in_valid` held high with no `start` → no writes.
